// File: rtl/definitions_pkg.sv
// Shared type and constant definitions for the execute/memory pipeline.
package definitions_pkg;

  localparam int unsigned XLEN = 32;

  // ALU operation select (consumed by the ALU; LSU uses the ALU_ADD result).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_e;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // Operation captured at accept and held for the whole transaction.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    mem_size_e       size;
    logic            is_unsigned;
    logic            is_store;
    logic [4:0]      rd;
  } lsu_op_t;

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replication and load shift/extend.
module lsu_align
  import definitions_pkg::*;
(
  input  mem_size_e        st_size,
  input  logic [1:0]       st_off,
  input  logic [XLEN-1:0]  st_data,
  output logic [3:0]       st_be_c,
  output logic [XLEN-1:0]  st_wdata_c,
  input  mem_size_e        ld_size,
  input  logic [1:0]       ld_off,
  input  logic             ld_unsigned,
  input  logic [XLEN-1:0]  ld_rdata,
  output logic [XLEN-1:0]  ld_data_c
);

  logic [XLEN-1:0] ld_shift;

  // Store path: enable the addressed lanes and replicate data onto all lanes.
  always_comb begin
    st_be_c    = 4'hF;
    st_wdata_c = st_data;
    case (st_size)
      MEM_B: begin
        st_be_c    = 4'b0001 << st_off;
        st_wdata_c = {4{st_data[7:0]}};
      end
      MEM_H: begin
        st_be_c    = 4'b0011 << st_off;
        st_wdata_c = {2{st_data[15:0]}};
      end
      default: begin
        st_be_c    = 4'hF;
        st_wdata_c = st_data;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift  = ld_rdata >> {ld_off, 3'b000};
    ld_data_c = ld_shift;
    case (ld_size)
      MEM_B:   ld_data_c = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      MEM_H:   ld_data_c = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data_c = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction at a time over req/gnt/rvalid.
module lsu
  import definitions_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_load,
  input  logic             ex_store,
  input  mem_size_e        ex_size,
  input  logic             ex_unsigned,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic [4:0]       ex_rd,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_err,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             exc_valid,
  output logic [3:0]       exc_cause,
  output logic [XLEN-1:0]  exc_addr
);

  localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

  lsu_state_e       state_q, state_d;
  lsu_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_ready_q, ex_ready_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]  dmem_addr_q, dmem_addr_d;
  logic [3:0]       dmem_be_q, dmem_be_d;
  logic [XLEN-1:0]  dmem_wdata_q, dmem_wdata_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             exc_valid_q, exc_valid_d;
  logic [3:0]       exc_cause_q, exc_cause_d;
  logic [XLEN-1:0]  exc_addr_q, exc_addr_d;

  logic [3:0]       st_be_c;
  logic [XLEN-1:0]  st_wdata_c;
  logic [XLEN-1:0]  ld_data_c;
  logic             accept_c;
  logic             misal_c;
  logic             timeout_c;

  lsu_align u_align (
    .st_size     (ex_size),
    .st_off      (ex_addr[1:0]),
    .st_data     (ex_wdata),
    .st_be_c     (st_be_c),
    .st_wdata_c  (st_wdata_c),
    .ld_size     (op_q.size),
    .ld_off      (op_q.addr[1:0]),
    .ld_unsigned (op_q.is_unsigned),
    .ld_rdata    (dmem_rdata),
    .ld_data_c   (ld_data_c)
  );

  // Accept only real memory ops; a request with neither load nor store is dropped.
  assign accept_c  = ex_valid && ex_ready_q && (ex_load || ex_store);
  assign misal_c   = is_misaligned(ex_size, ex_addr[1:0]);
  assign timeout_c = (RESP_TIMEOUT != 0) && (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    exc_valid_d  = 1'b0;
    exc_cause_d  = exc_cause_q;
    exc_addr_d   = exc_addr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept_c) begin
          if (misal_c) begin
            exc_valid_d = 1'b1;
            exc_cause_d = ex_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
            exc_addr_d  = ex_addr;
          end else begin
            op_d.addr        = ex_addr;
            op_d.size        = ex_size;
            op_d.is_unsigned = ex_unsigned;
            op_d.is_store    = ~ex_load;
            op_d.rd          = ex_rd;
            dmem_req_d       = 1'b1;
            dmem_we_d        = ~ex_load;
            dmem_addr_d      = {ex_addr[XLEN-1:2], 2'b00};
            dmem_be_d        = st_be_c;
            dmem_wdata_d     = ex_load ? '0 : st_wdata_c;
            state_d          = REQ;
          end
        end
      end

      REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          cnt_d      = '0;
          state_d    = RESP;
        end
      end

      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          if (dmem_err) begin
            exc_valid_d = 1'b1;
            exc_cause_d = op_q.is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
            exc_addr_d  = op_q.addr;
          end else if (!op_q.is_store) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = op_q.rd;
            wb_data_d  = ld_data_c;
          end
          dmem_we_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (timeout_c) begin
          exc_valid_d = 1'b1;
          exc_cause_d = op_q.is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
          exc_addr_d  = op_q.addr;
          dmem_we_d   = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    ex_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      ex_ready_q   <= 1'b1;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= '0;
      exc_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      ex_ready_q   <= ex_ready_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      exc_valid_q  <= exc_valid_d;
      exc_cause_q  <= exc_cause_d;
      exc_addr_q   <= exc_addr_d;
    end
  end

  assign ex_ready   = ex_ready_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = exc_cause_q;
  assign exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single transactions plus corner sequences.
module tb_lsu;
  import definitions_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_load, ex_store, ex_unsigned;
  mem_size_e   ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [3:0]  exc_cause;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  lsu #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] exp_addr;
    logic        chk_be;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_wb;
    logic [31:0] exp_wb_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_load     = ld;
    ex_store    = st;
    ex_size     = mem_size_e'(size);
    ex_unsigned = uns;
    ex_addr     = addr;
    ex_wdata    = wdata;
    ex_rd       = rd;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
  endtask

  // One transaction with immediate grant and a response on the following cycle.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive_op(v.ld, v.st, v.size, v.uns, v.addr, v.wdata, v.rd);
    step();                                     // cycle 1: request out
    idle_ex();
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_ready_busy"}, 32'(ex_ready), 32'd0);
    check({tag, "_addr"}, dmem_addr, v.exp_addr);
    check({tag, "_we"}, 32'(dmem_we), 32'(v.exp_we));
    if (v.chk_be) check({tag, "_be"}, 32'(dmem_be), 32'(v.exp_be));
    if (v.st) check({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
    dmem_gnt = 1'b1;
    step();                                     // cycle 2: response
    dmem_gnt    = 1'b0;
    check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_err    = 1'b0;
    dmem_rdata  = v.rdata;
    step();                                     // cycle 3: writeback
    dmem_rvalid = 1'b0;
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'(v.exp_wb));
    if (v.exp_wb) begin
      check({tag, "_wb_data"}, wb_data, v.exp_wb_data);
      check({tag, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
    end
    check({tag, "_exc"}, 32'(exc_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(ex_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ex();
    ex_size = MEM_W; ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;

    //           ld    st    size   uns   addr          wdata         rdata         rd     exp_addr      chkbe  be       we    exp_wdata     wb    wb_data
    vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 5'd5, 32'h0000_1000, 1'b1, 4'hF,    1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 5'd6, 32'h0000_1000, 1'b0, 4'h0,    1'b0, 32'h0,        1'b1, 32'hFFFF_FF80};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 5'd7, 32'h0000_1000, 1'b0, 4'h0,    1'b0, 32'h0,        1'b1, 32'h0000_0080};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0,        32'hBEEF_1234, 5'd8, 32'h0000_1000, 1'b0, 4'h0,    1'b0, 32'h0,        1'b1, 32'h0000_BEEF};
    vecs[4] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5, 32'h0,       5'd0, 32'h0000_2000, 1'b1, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0,        32'h8000_1234, 5'd9, 32'h0000_1000, 1'b0, 4'h0,    1'b0, 32'h0,        1'b1, 32'hFFFF_8000};
    vecs[6] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2004, 32'h1234_5678, 32'h0,       5'd0, 32'h0000_2004, 1'b1, 4'hF,    1'b1, 32'h1234_5678, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_CAFE, 32'h0,       5'd0, 32'h0000_2000, 1'b1, 4'b1100, 1'b1, 32'hCAFE_CAFE, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0,        32'h0000_7F00, 5'd10, 32'h0000_1000, 1'b0, 4'h0,   1'b0, 32'h0,        1'b1, 32'h0000_007F};
    // load and store both high behaves as a load
    vecs[9] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_1100, 32'hFFFF_FFFF, 32'h0BAD_F00D, 5'd11, 32'h0000_1100, 1'b1, 4'hF,  1'b0, 32'h0,        1'b1, 32'h0BAD_F00D};

    // Reset state
    step();
    check("rst_ready", 32'(ex_ready), 32'd1);
    check("rst_outs", {26'd0, dmem_req, dmem_we, wb_valid, exc_valid, 2'b00}, 32'd0);
    check("rst_bus", dmem_addr | dmem_wdata | wb_data | exc_addr | 32'(dmem_be) | 32'(exc_cause) | 32'(wb_rd), 32'd0);
    rst_n = 1'b1;
    step();

    // Table-driven single transactions, back to back
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Misaligned LW: exception, no memory access, single-cycle pulse
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 5'd3);
    step();
    idle_ex();
    check("mis_lw_exc", 32'(exc_valid), 32'd1);
    check("mis_lw_cause", 32'(exc_cause), 32'd4);
    check("mis_lw_addr", exc_addr, 32'h0000_1002);
    check("mis_lw_noreq", 32'(dmem_req), 32'd0);
    check("mis_lw_nowb", 32'(wb_valid), 32'd0);
    check("mis_lw_ready", 32'(ex_ready), 32'd1);
    step();
    check("mis_lw_pulse", 32'(exc_valid), 32'd0);
    check("mis_lw_noreq2", 32'(dmem_req), 32'd0);

    // Misaligned SH
    drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1234, 5'd0);
    step();
    idle_ex();
    check("mis_sh_exc", 32'(exc_valid), 32'd1);
    check("mis_sh_cause", 32'(exc_cause), 32'd6);
    check("mis_sh_addr", exc_addr, 32'h0000_3001);
    check("mis_sh_noreq", 32'(dmem_req), 32'd0);
    step();

    // Neither load nor store: dropped
    drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 5'd1);
    step();
    idle_ex();
    check("drop_quiet", {29'd0, dmem_req, wb_valid, exc_valid}, 32'd0);
    check("drop_ready", 32'(ex_ready), 32'd1);

    // Grant withheld 5 cycles on SW 0x4000, stray rvalid in REQ ignored, then bus error
    drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h1122_3344, 5'd0);
    step();
    idle_ex();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_ctl", c), {29'd0, dmem_req, dmem_we, ex_ready}, 32'b110);
      check($sformatf("stall%0d_addr", c), dmem_addr, 32'h0000_4000);
      check($sformatf("stall%0d_be", c), 32'(dmem_be), 32'hF);
      check($sformatf("stall%0d_wdata", c), dmem_wdata, 32'h1122_3344);
      dmem_rvalid = (c == 2);
      step();
      dmem_rvalid = 1'b0;
    end
    check("stall_noexc", {30'd0, wb_valid, exc_valid}, 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_err    = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    check("sterr_exc", 32'(exc_valid), 32'd1);
    check("sterr_cause", 32'(exc_cause), 32'd7);
    check("sterr_addr", exc_addr, 32'h0000_4000);
    check("sterr_nowb", 32'(wb_valid), 32'd0);
    check("sterr_ready", 32'(ex_ready), 32'd1);
    step();

    // Response timeout on LW 0x5000: fault four cycles after entering RESP
    begin
      int seen;
      seen = -1;
      drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 5'd4);
      step();
      idle_ex();
      dmem_gnt = 1'b1;
      step();                                   // first RESP cycle
      dmem_gnt = 1'b0;
      for (int n = 0; n < 20 && seen < 0; n++) begin
        if (exc_valid) seen = n;
        else step();
      end
      check("tmo_latency", 32'(seen), 32'd4);
      check("tmo_cause", 32'(exc_cause), 32'd5);
      check("tmo_addr", exc_addr, 32'h0000_5000);
      check("tmo_nowb", 32'(wb_valid), 32'd0);
      check("tmo_ready", 32'(ex_ready), 32'd1);
      step();
    end

    // Reset during RESP: immediate IDLE, late rvalid ignored
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd7);
    step();
    idle_ex();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("rstmid_busy", 32'(ex_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", 32'(ex_ready), 32'd1);
    check("rstmid_req", 32'(dmem_req), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    check("rstmid_nowb", 32'(wb_valid), 32'd0);
    check("rstmid_noexc", 32'(exc_valid), 32'd0);
    check("rstmid_idle", 32'(ex_ready), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Writeback and exception pulses must never overlap.
  always @(negedge clk) begin
    if (rst_n && wb_valid && exc_valid) begin
      n_total++;
      $display("FAIL wb_exc_overlap: got both high expected exclusive");
    end
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the ALU.
- Consumes the ALU result as the effective address and rs2 as store data, then runs one data-memory transaction over a req/gnt/rvalid handshake.
- Returns aligned, sign- or zero-extended load data to writeback, or raises a misaligned or access-fault exception.
- One transaction outstanding at a time; the execute stage stalls on ex_ready.

Parameters:
- RESP_TIMEOUT, 255: cycles to wait in RESP before declaring an access fault; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents a memory operation.
- ex_ready  out  1  LSU can accept an operation this cycle.
- ex_load  in  1  operation is a load.
- ex_store  in  1  operation is a store.
- ex_size  in  2 (mem_size_e)  access size: MEM_B, MEM_H or MEM_W.
- ex_unsigned  in  1  zero-extend load data (LBU/LHU).
- ex_addr  in  32  effective address (ALU_ADD result).
- ex_wdata  in  32  store data (rs2).
- ex_rd  in  5  load destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address; bits [1:0] are always 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  response valid; used for both load data and store acknowledge.
- dmem_rdata  in  32  read data.
- dmem_err  in  1  bus error, qualified by dmem_rvalid.
- wb_valid  out  1  one-cycle pulse: load result ready.
- wb_rd  out  5  load destination register.
- wb_data  out  32  extended load result.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  4  mcause code.
- exc_addr  out  32  faulting byte address (mtval).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0 except ex_ready=1.
  - Reset asserted mid-transaction abandons the transaction; any dmem_rvalid arriving later in IDLE is ignored.
- States: IDLE, REQ, RESP. ex_ready = (state==IDLE).
- IDLE, accept on ex_valid && ex_ready:
  - Misaligned access (MEM_H with addr[0]=1, or MEM_W with addr[1:0]!=0): no memory access. Next cycle exc_valid=1, exc_addr=ex_addr, exc_cause=4 (load) or 6 (store). Stay in IDLE.
  - Aligned access: register the operation and go to REQ.
  - ex_load and ex_store both high: treated as a load.
  - Neither high: dropped silently.
- REQ:
  - dmem_req=1; dmem_addr, dmem_we, dmem_be and dmem_wdata are driven from registers and held stable until gnt.
  - On dmem_gnt: drop dmem_req next cycle and go to RESP.
  - dmem_rvalid is ignored in REQ.
- RESP:
  - The timeout counter increments each cycle.
  - On dmem_rvalid with dmem_err=0:
    - load: next cycle wb_valid=1 with wb_rd and wb_data;
    - store: no writeback.
  - On dmem_rvalid with dmem_err=1: next cycle exc_valid=1, exc_cause=5 (load) or 7 (store), exc_addr = original byte address, no writeback.
  - If RESP_TIMEOUT!=0 and the counter reaches RESP_TIMEOUT before rvalid: same fault as dmem_err.
  - Any exit from RESP returns to IDLE and clears the counter.
  - dmem_rvalid and a timeout in the same cycle: the response wins.
- Latency, aligned load with gnt in the first REQ cycle and rvalid the next cycle:
  - accept at cycle 0, dmem_req at cycle 1, rvalid at cycle 2, wb_valid at cycle 3;
  - next accept possible at cycle 3 (ex_ready=1).
- Store lanes, o = addr[1:0]:
  - MEM_B: be = 4'b0001<<o; wdata = byte replicated ×4.
  - MEM_H: be = 4'b0011<<o; wdata = halfword replicated ×2.
  - MEM_W: be = 4'b1111; wdata as given.
- Load extract: shift rdata right by 8*o, take 8/16/32 bits, then sign-extend, or zero-extend when unsigned was registered.
- wb_valid and exc_valid are never high in the same cycle; both pulse for exactly 1 cycle.

Decomposition:
- definitions_pkg (alongside alu_e):
  - mem_size_e {MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10};
  - lsu_state_e {IDLE, REQ, RESP};
  - mcause constants EXC_LD_MISALIGN=4, EXC_LD_FAULT=5, EXC_ST_MISALIGN=6, EXC_ST_FAULT=7.
- One combinational sub-module, lsu_align: store byte-enable/replication and load shift/extend. It is shared logic and is unit-testable alone.

Test Plan:
- LW from 0x1000, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF, rd=5 -> dmem_addr=0x1000, be=4'hF, we=0; wb_valid exactly at cycle 3, wb_rd=5, wb_data=0xDEADBEEF.
- LB from 0x1003 with rdata=0x80FFFFFF -> wb_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU from 0x1002 with rdata=0xBEEF1234 -> 0x0000BEEF.
- SB to 0x2001 with wdata=0x000000A5 -> dmem_addr=0x2000, be=4'b0010, wdata=0xA5A5A5A5, we=1; rvalid produces no wb_valid.
- LW from 0x1002 -> no dmem_req ever; exc_valid one cycle after accept, cause=4, addr=0x1002. SH to 0x3001 -> cause=6.
- gnt held low for 5 cycles -> dmem_req and all request fields stable, ex_ready=0 throughout. Then rvalid with err=1 on a store to 0x4000 -> exc_valid, cause=7, addr=0x4000.
- RESP_TIMEOUT=4, no rvalid -> cause=5 four cycles into RESP. Separately, rst_n low while in RESP -> immediate IDLE and ex_ready=1; a late rvalid produces no wb_valid.
